dds_moving_avg: RTL and testbench

Windowed moving-average filter and controller for the DDS tapped delay line. Accepts samples on a valid/ready stream and writes each accepted sample into the external delay line. Reads back the tap for the selected window length and keeps a running sum, y = sum of the last N samples shifted right by log2 N. Sits between the DDS sample source and the output AXI-stream wrapper.

---
 rtl/dds_moving_avg_pkg.sv | 28 ++
 rtl/dds_moving_avg.sv | 141 ++++++++++++++
 tb/tb_dds_moving_avg.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_moving_avg_pkg.sv
// Shared definitions for the DDS moving-average filter: FSM encoding and
// window-length helpers (window N = 8 << len, len in 0..5).
package dds_moving_avg_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [2:0] LEN_SEL_MAX = 3'd5;

    function automatic logic [2:0] clamp_len(input logic [2:0] sel);
        return (sel > LEN_SEL_MAX) ? LEN_SEL_MAX : sel;
    endfunction

    function automatic logic [3:0] len_log2(input logic [2:0] len);
        return {1'b0, len} + 4'd3;
    endfunction

    // Index of the last accept of a fill: N-1
    function automatic logic [7:0] len_last(input logic [2:0] len);
        logic [8:0] n;
        n = 9'd1 << len_log2(len);
        return 8'(n - 9'd1);
    endfunction

endpackage

// File: rtl/dds_moving_avg.sv
// Windowed moving average over an external tapped delay line: running sum of
// the last N accepted samples, arithmetically shifted right by log2 N.
module dds_moving_avg
    import dds_moving_avg_pkg::*;
#(
    parameter int SIG_WIDTH = 16,
    parameter int ACC_WIDTH = SIG_WIDTH + 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [SIG_WIDTH-1:0] s_data,
    input  logic        [2:0]           len_sel,
    output logic                        sr_en,
    output logic                        sr_clr,
    output logic signed [SIG_WIDTH-1:0] sr_din,
    input  logic signed [SIG_WIDTH-1:0] tap_8,
    input  logic signed [SIG_WIDTH-1:0] tap_16,
    input  logic signed [SIG_WIDTH-1:0] tap_32,
    input  logic signed [SIG_WIDTH-1:0] tap_64,
    input  logic signed [SIG_WIDTH-1:0] tap_128,
    input  logic signed [SIG_WIDTH-1:0] tap_256,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [SIG_WIDTH-1:0] m_data,
    output logic                        filled
);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic signed [ACC_WIDTH-1:0]   r_acc;
    logic        [7:0]             r_fill_cnt;
    logic        [2:0]             r_len_q;
    logic                          r_m_valid;
    logic signed [SIG_WIDTH-1:0]   r_m_data;
    logic                          r_filled;

    logic                          w_accept;
    logic        [2:0]             w_len_sel;
    logic                          w_len_chg;
    logic                          w_fill_done;
    logic signed [SIG_WIDTH-1:0]   w_tap;
    logic signed [ACC_WIDTH-1:0]   w_s_ext;
    logic signed [ACC_WIDTH-1:0]   w_tap_ext;
    logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
    logic signed [SIG_WIDTH-1:0]   w_avg;

    assign w_accept    = s_valid && s_ready;
    assign w_len_sel   = clamp_len(len_sel);
    assign w_len_chg   = (w_len_sel != r_len_q);
    assign w_fill_done = w_accept && (r_fill_cnt == len_last(r_len_q));

    always_comb begin
        case (r_len_q)
            3'd0:    w_tap = tap_8;
            3'd1:    w_tap = tap_16;
            3'd2:    w_tap = tap_32;
            3'd3:    w_tap = tap_64;
            3'd4:    w_tap = tap_128;
            default: w_tap = tap_256;
        endcase
    end

    // Cleared taps read zero, so partial-window sums are already exact
    assign w_s_ext   = {{(ACC_WIDTH-SIG_WIDTH){s_data[SIG_WIDTH-1]}}, s_data};
    assign w_tap_ext = {{(ACC_WIDTH-SIG_WIDTH){w_tap[SIG_WIDTH-1]}}, w_tap};
    assign w_acc_nxt = r_acc + w_s_ext - w_tap_ext;
    assign w_avg     = SIG_WIDTH'(w_acc_nxt >>> len_log2(r_len_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FLUSH: w_state_nxt = ST_FILL;
            ST_FILL: begin
                if (w_len_chg)        w_state_nxt = ST_FLUSH;
                else if (w_fill_done) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_len_chg)        w_state_nxt = ST_FLUSH;
            end
            default:                  w_state_nxt = ST_FLUSH;
        endcase
    end

    // The clear pulse is masked while rst_n is low so reset drives every output to 0
    always_comb begin
        s_ready = (r_state != ST_FLUSH) && (!r_m_valid || m_ready);
        sr_clr  = (r_state == ST_FLUSH) && rst_n;
        sr_en   = w_accept;
        sr_din  = s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_fill_cnt <= '0;
            r_len_q    <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_filled   <= 1'b0;
        end else begin
            if (r_state == ST_FLUSH) begin
                r_acc      <= '0;
                r_fill_cnt <= '0;
                r_len_q    <= w_len_sel;
            end else if (w_accept) begin
                r_acc <= w_acc_nxt;
                if (r_state == ST_FILL && !w_fill_done) begin
                    r_fill_cnt <= r_fill_cnt + 8'd1;
                end
            end

            if (r_state != ST_FLUSH && w_len_chg) begin
                r_filled <= 1'b0;
            end else if (r_state == ST_FILL && w_fill_done) begin
                r_filled <= 1'b1;
            end

            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_avg;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign filled  = r_filled;

endmodule

// File: tb/tb_dds_moving_avg.sv
// Scoreboard bench for dds_moving_avg: models the external delay line and
// predicts each average as floor(sum of the last N accepted samples / N).
module tb_dds_moving_avg;

    localparam int SW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 m_ready = 1'b1;
    logic        [2:0]    len_sel = 3'd0;
    logic signed [SW-1:0] s_data = '0;
    logic                 s_ready, sr_en, sr_clr, m_valid, filled;
    logic signed [SW-1:0] sr_din, m_data;
    logic signed [SW-1:0] tap_8, tap_16, tap_32, tap_64, tap_128, tap_256;
    logic signed [SW-1:0] dl [0:255];

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int clr_cnt = 0;
    int srdy_low_cnt = 0;
    int mdl_len = 0;
    int hist[$];
    int exp_q[$];

    always #5 clk = ~clk;

    dds_moving_avg #(.SIG_WIDTH(SW), .ACC_WIDTH(SW + 8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .len_sel(len_sel), .sr_en(sr_en), .sr_clr(sr_clr),
        .sr_din(sr_din), .tap_8(tap_8), .tap_16(tap_16), .tap_32(tap_32),
        .tap_64(tap_64), .tap_128(tap_128), .tap_256(tap_256),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .filled(filled)
    );

    // External delay line: dl[k] holds the sample written k+1 shifts ago
    always @(posedge clk) begin
        if (sr_clr) begin
            for (int i = 0; i < 256; i++) dl[i] <= '0;
        end else if (sr_en) begin
            for (int i = 255; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= sr_din;
        end
    end
    assign tap_8   = dl[7];
    assign tap_16  = dl[15];
    assign tap_32  = dl[31];
    assign tap_64  = dl[63];
    assign tap_128 = dl[127];
    assign tap_256 = dl[255];

    function automatic int clampf(input int s);
        return (s > 5) ? 5 : s;
    endfunction

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic int mdl_avg();
        int n, sum, k;
        n = 8 << mdl_len;
        sum = 0;
        k = hist.size();
        for (int i = 0; i < n && i < k; i++) sum += hist[k-1-i];
        return floor_div(sum, n);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on output handshakes, pushes predictions on input handshakes
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hist.delete();
            mdl_len = clampf(int'(len_sel));
        end else begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 1, 0);
                else check("m_data", int'(m_data), exp_q.pop_front());
            end
            if (m_valid && !m_ready) check("bp_s_ready", int'(s_ready), 0);
            check("sr_en", int'(sr_en), int'(s_valid && s_ready));
            if (sr_en) check("sr_din", int'(sr_din), int'(s_data));
            if (s_valid && s_ready) begin
                hist.push_back(int'(s_data));
                if (hist.size() > 256) void'(hist.pop_front());
                exp_q.push_back(mdl_avg());
                acc_cnt++;
            end
            if (clampf(int'(len_sel)) != mdl_len) begin
                hist.delete();
                mdl_len = clampf(int'(len_sel));
            end
            if (sr_clr) clr_cnt++;
            if (!s_ready) srdy_low_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input int budget);
        int c;
        c = 0;
        while (acc_cnt < target && c < budget) begin
            tick();
            c++;
        end
        if (acc_cnt < target) check("accept_timeout", acc_cnt, target);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_valid"}, int'(m_valid), 0);
        check({tag, "_m_data"},  int'(m_data), 0);
        check({tag, "_filled"},  int'(filled), 0);
        check({tag, "_s_ready"}, int'(s_ready), 0);
        check({tag, "_sr_en"},   int'(sr_en), 0);
        check({tag, "_sr_clr"},  int'(sr_clr), 0);
    endtask

    task automatic change_window(input logic [2:0] sel);
        int c0, l0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        c0 = clr_cnt;
        l0 = srdy_low_cnt;
        len_sel = sel;
        repeat (3) tick();
        check("flush_clr_pulses", clr_cnt - c0, 1);
        check("flush_sready_low", srdy_low_cnt - l0, 1);
    endtask

    initial begin
        int base, c0, l0;
        logic signed [SW-1:0] hold;

        // Reset state, then constant +800 at N=8
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("post_reset_sr_clr", int'(sr_clr), 1);
        check("post_reset_s_ready", int'(s_ready), 0);
        tick();
        check("fill_sr_clr", int'(sr_clr), 0);
        check("fill_s_ready", int'(s_ready), 1);
        base = acc_cnt;
        s_valid = 1'b1;
        s_data = 16'sd800;
        wait_acc(base + 7, 50);
        check("const_filled_7", int'(filled), 0);
        check("const_ramp_7", int'(m_data), 700);
        wait_acc(base + 8, 50);
        check("const_filled_8", int'(filled), 1);
        check("const_ramp_8", int'(m_data), 800);
        wait_acc(base + 20, 50);
        check("const_steady", int'(m_data), 800);

        // Impulse at N=16
        change_window(3'd1);
        base = acc_cnt;
        s_valid = 1'b1;
        s_data = 16'sd1600;
        tick();
        s_data = 16'sd0;
        wait_acc(base + 24, 100);

        // Constant -1 at N=8: floor keeps every output at -1
        change_window(3'd0);
        base = acc_cnt;
        s_valid = 1'b1;
        s_data = -16'sd1;
        wait_acc(base + 12, 50);
        check("neg_steady", int'(m_data), -1);

        // Random traffic at N=32 with an explicit 5-cycle stall
        change_window(3'd2);
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(3) != 0);
            s_data = SW'($urandom);
            m_ready = ($urandom_range(3) != 0);
            if (i == 200) begin
                s_valid = 1'b1;
                m_ready = 1'b1;
                tick();
                m_ready = 1'b0;
                hold = m_data;
                for (int j = 0; j < 5; j++) begin
                    #1;
                    check("stall_s_ready", int'(s_ready), 0);
                    check("stall_sr_en", int'(sr_en), 0);
                    check("stall_m_data", int'(m_data), int'(hold));
                    tick();
                end
                m_ready = 1'b1;
            end
            tick();
        end

        // Window change 0 -> 5 during RUN with streaming input
        change_window(3'd0);
        s_valid = 1'b1;
        s_data = 16'sd512;
        wait_acc(acc_cnt + 20, 50);
        check("run_filled_n8", int'(filled), 1);
        c0 = clr_cnt;
        l0 = srdy_low_cnt;
        len_sel = 3'd5;
        tick();
        base = acc_cnt;
        check("chg_filled_drop", int'(filled), 0);
        wait_acc(base + 255, 400);
        check("n256_filled_255", int'(filled), 0);
        wait_acc(base + 256, 50);
        check("n256_filled_256", int'(filled), 1);
        check("n256_const512", int'(m_data), 512);
        check("chg_clr_pulses", clr_cnt - c0, 1);
        check("chg_sready_low", srdy_low_cnt - l0, 1);

        // len_sel 7 clamps to the current window: no flush
        c0 = clr_cnt;
        len_sel = 3'd7;
        repeat (4) tick();
        check("clamp_no_flush", clr_cnt - c0, 0);
        check("clamp_filled", int'(filled), 1);

        // Full scale negative at N=256
        s_data = -16'sd32768;
        wait_acc(acc_cnt + 300, 400);
        check("fullscale", int'(m_data), -32768);

        // Asynchronous reset in the middle of random RUN traffic
        for (int i = 0; i < 10; i++) begin
            s_data = SW'($urandom);
            tick();
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        s_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rel_sr_clr", int'(sr_clr), 1);
        tick();
        check("rel_sr_clr_done", int'(sr_clr), 0);
        base = acc_cnt;
        s_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            s_data = SW'($urandom);
            m_ready = ($urandom_range(4) != 0);
            tick();
        end

        // Drain
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
